// File: rtl/csa_seq_acc.sv
// Sequence accumulator: operands are folded into a carry-save pair (s, c) with no
// carry-propagate add on the accept path; one resolve cycle produces the binary sum.
module csa_seq_acc #(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [W-1:0]     out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat,
  input  logic             out_rdy
);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nxt;
  logic [W-1:0]     s;
  logic [W-1:0]     c;
  logic [W-1:0]     maj;
  logic [W-1:0]     sum_q;
  logic [CNT_W-1:0] cnt;
  logic             sat;
  logic             accept;

  assign in_rdy  = (state == IDLE) || (state == ACC);
  assign out_vld = (state == DONE);
  assign accept  = in_vld && in_rdy;
  assign out_sum = sum_q;
  assign out_cnt = cnt;
  assign out_sat = sat;

  // 3:2 compressor carries; shifting left drops the weight-2^W carry (modulo sum)
  assign maj = (s & c) | (s & in_data) | (c & in_data);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: if (in_vld) state_nxt = in_last ? RESOLVE : ACC;
      RESOLVE:   state_nxt = DONE;
      DONE:      if (out_rdy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      c     <= '0;
      cnt   <= '0;
      sat   <= 1'b0;
      sum_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (state == IDLE) begin
          s   <= in_data;
          c   <= '0;
          cnt <= CNT_ONE;
          sat <= 1'b0;
        end else begin
          s <= s ^ c ^ in_data;
          c <= {maj[W-2:0], 1'b0};
          // The count sticks at its maximum; sat records that operands were lost from it
          if (cnt == CNT_MAX) sat <= 1'b1;
          else                cnt <= cnt + CNT_ONE;
        end
      end
      if (state == RESOLVE) sum_q <= s + c;
    end
  end

endmodule
